// File: rtl/sprite_line_fetcher_if.sv
// Sprite ROM read bus shared between sprite_line_fetcher and the sprite ROM.
//   read_address : ADDR_W-bit ROM word address (driven by the fetcher)
//   rom_color    : 24-bit colour returned combinationally by the ROM
// Modports:
//   master : fetcher side (drives read_address, samples rom_color)
//   slave  : ROM side     (samples read_address, drives rom_color)
interface sprite_line_fetcher_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] read_address;
    logic [23:0]       rom_color;

    modport master (output read_address, input  rom_color);
    modport slave  (input  read_address, output rom_color);
endinterface

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
// Caches one row of a palette-indexed sprite ROM per scanline in a ping-pong
// line buffer. During horizontal blank the next scanline's ROM row is walked
// into the back buffer; during the active line the front buffer is served at
// DrawX with a one-cycle registered latency plus an opaque flag.
//
// Build option: define SPRITE_FLIP_EN to honour the horizontal mirror input
// (flip). Without it flip is ignored and no mirror logic is built.
//
// Ports:
//   Clk          in   pixel-domain clock
//   Reset_n      in   asynchronous active-low reset
//   line_start   in   1-cycle pulse at start of hblank (next_y valid same cycle)
//   next_y       in   scanline about to be displayed
//   sprite_x     in   sprite left edge, sampled on line_start
//   sprite_y     in   sprite top edge, sampled on line_start
//   flip         in   horizontal mirror request, sampled on line_start
//   DrawX        in   current pixel column
//   rom          --   sprite ROM bus (master: read_address out, rom_color in)
//   pixel_color  out  sprite colour for the DrawX of the previous cycle
//   pixel_opaque out  1 = pixel_color valid and not transparent
//   busy         out  ROM row fetch in progress
module sprite_line_fetcher #(
    parameter int          SPR_W        = 21,
    parameter int          SPR_H        = 21,
    parameter int          ADDR_W       = 9,
    parameter logic [23:0] TRANSP_COLOR = 24'h800080
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     line_start,
    input  logic [9:0]               next_y,
    input  logic [9:0]               sprite_x,
    input  logic [9:0]               sprite_y,
    input  logic                     flip,
    input  logic [9:0]               DrawX,
    sprite_line_fetcher_if.master    rom,
    output logic [23:0]              pixel_color,
    output logic                     pixel_opaque,
    output logic                     busy
);

    localparam int              CW       = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [CW-1:0]   LAST_COL = CW'(SPR_W - 1);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state_q, state_d;

    // Control strobes from the FSM
    logic start;      // line_start accepted: swap buffers, evaluate hit
    logic write_en;   // write current ROM word into back buffer

    // Buffer bookkeeping
    logic          sel_q;     // index of the front (displayed) buffer
    logic          back_sel;
    logic [1:0]    valid_q;   // per-buffer "complete row" flag
    logic [CW-1:0] col_q;     // column being fetched
    logic          last_col;

    // Front-line registers sampled on line_start
    logic [9:0] sx_q;

    // Line buffers (data only, no reset needed: guarded by valid_q)
    logic [23:0] line_color  [2][SPR_W];
    logic        line_opaque [2][SPR_W];

    // Hit evaluation, 11-bit unsigned so rows past 1023 never wrap into range
    logic [10:0] ny, sy, row;
    logic        hit;

    assign ny       = {1'b0, next_y};
    assign sy       = {1'b0, sprite_y};
    assign hit      = (ny >= sy) && (ny < (sy + 11'(SPR_H)));
    assign row      = ny - sy;
    assign back_sel = ~sel_q;
    assign last_col = (col_q == LAST_COL);
    assign busy     = (state_q == FETCH);

    //--------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------
    // FSM next state / strobes. line_start wins over an in-flight fetch,
    // which aborts it: the partial row is swapped to the front still invalid.
    //--------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        write_en = 1'b0;
        if (line_start) begin
            start   = 1'b1;
            state_d = hit ? FETCH : IDLE;
        end else if (state_q == FETCH) begin
            write_en = 1'b1;
            if (last_col) begin
                state_d = IDLE;
            end
        end
    end

    //--------------------------------------------------------------------
    // Fetch datapath: buffer select, valid flags, column, ROM address
    //--------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_q            <= 1'b0;
            valid_q          <= '0;
            col_q            <= '0;
            rom.read_address <= '0;
            sx_q             <= '0;
        end else if (start) begin
            // Old front becomes the new back and is invalidated; the old
            // back (possibly complete) becomes front with its flag intact.
            sel_q          <= back_sel;
            valid_q[sel_q] <= 1'b0;
            sx_q           <= sprite_x;
            col_q          <= '0;
            if (hit) begin
                rom.read_address <= ADDR_W'(row * SPR_W);
            end
        end else if (write_en) begin
            if (last_col) begin
                valid_q[back_sel] <= 1'b1;
            end else begin
                col_q            <= col_q + CW'(1);
                rom.read_address <= rom.read_address + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (write_en) begin
            line_color[back_sel][col_q]  <= rom.rom_color;
            line_opaque[back_sel][col_q] <= (rom.rom_color != TRANSP_COLOR);
        end
    end

    //--------------------------------------------------------------------
    // Mirror option
    //--------------------------------------------------------------------
`ifdef SPRITE_FLIP_EN
    logic flip_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flip_q <= 1'b0;
        end else if (start) begin
            flip_q <= flip;
        end
    end
`else
    logic flip_unused;
    assign flip_unused = flip;
`endif

    //--------------------------------------------------------------------
    // Render
    //--------------------------------------------------------------------
    logic [10:0]   dx;
    logic          in_span;
    logic [CW-1:0] col_r;
    logic [CW-1:0] col_idx;

    always_comb begin
        dx      = {1'b0, DrawX} - {1'b0, sx_q};
        in_span = (DrawX >= sx_q) && (dx < 11'(SPR_W)) && valid_q[sel_q];
`ifdef SPRITE_FLIP_EN
        col_r   = flip_q ? (LAST_COL - dx[CW-1:0]) : dx[CW-1:0];
`else
        col_r   = dx[CW-1:0];
`endif
        // Keep the buffer index in range when outside the sprite span
        col_idx = in_span ? col_r : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_color  <= '0;
            pixel_opaque <= 1'b0;
        end else begin
            pixel_color  <= in_span ? line_color[sel_q][col_idx] : '0;
            pixel_opaque <= in_span & line_opaque[sel_q][col_idx];
        end
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;

    localparam int          W      = 21;
    localparam int          H      = 21;
    localparam logic [23:0] TRANSP = 24'h800080;

`ifdef SPRITE_FLIP_EN
    localparam bit FLIP_BUILD = 1'b1;
`else
    localparam bit FLIP_BUILD = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0;
    logic [9:0]  sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic        flip = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [23:0] pixel_color;
    logic        pixel_opaque;
    logic        busy;

    logic [23:0] rom [512];

    int tests  = 0;
    int failed = 0;

    sprite_line_fetcher_if #(.ADDR_W(9)) rom_bus ();

    assign rom_bus.rom_color = rom[rom_bus.read_address];

    sprite_line_fetcher #(
        .SPR_W(W),
        .SPR_H(H),
        .ADDR_W(9),
        .TRANSP_COLOR(TRANSP)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .line_start(line_start),
        .next_y(next_y),
        .sprite_x(sprite_x),
        .sprite_y(sprite_y),
        .flip(flip),
        .DrawX(DrawX),
        .rom(rom_bus),
        .pixel_color(pixel_color),
        .pixel_opaque(pixel_opaque),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line-level behavioural model ----------------
    // Tracks which ROM row is on screen and which is being fetched; a fetch
    // counts as complete once 21 clocks pass with no new line_start.
    int          disp_row = 0, disp_sx = 0;
    bit          disp_valid = 0, disp_flip = 0;
    int          pend_row = 0, fetch_left = 0;
    bit          pend_valid = 0;
    int          m_addr = 0;
    logic [23:0] m_color = '0;
    bit          m_opaque = 0;
    int          mc;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            disp_row = 0; disp_sx = 0; disp_valid = 0; disp_flip = 0;
            pend_row = 0; pend_valid = 0; fetch_left = 0;
            m_addr = 0; m_color = '0; m_opaque = 0;
        end else begin
            if (disp_valid && int'(DrawX) >= disp_sx && int'(DrawX) < disp_sx + W) begin
                mc = int'(DrawX) - disp_sx;
                if (FLIP_BUILD && disp_flip) mc = W - 1 - mc;
                m_color  = rom[disp_row * W + mc];
                m_opaque = (m_color != TRANSP);
            end else begin
                m_color  = '0;
                m_opaque = 0;
            end
            if (line_start) begin
                disp_valid = pend_valid && (fetch_left == 0);
                disp_row   = pend_row;
                disp_sx    = int'(sprite_x);
                disp_flip  = flip;
                if (int'(next_y) >= int'(sprite_y) && int'(next_y) < int'(sprite_y) + H) begin
                    pend_valid = 1;
                    pend_row   = int'(next_y) - int'(sprite_y);
                    fetch_left = W;
                    m_addr     = pend_row * W;
                end else begin
                    pend_valid = 0;
                    fetch_left = 0;
                end
            end else if (fetch_left > 0) begin
                fetch_left--;
                if (fetch_left > 0) m_addr++;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset_n) begin
            check("pixel_color",  32'(pixel_color),          32'(m_color));
            check("pixel_opaque", 32'(pixel_opaque),         32'(m_opaque));
            check("busy",         32'(busy),                 32'(fetch_left > 0));
            check("read_address", 32'(rom_bus.read_address), 32'(m_addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // Position inputs are scrambled after the pulse: only sampled values matter
    task automatic pulse_line(input int ny, input int sx, input int sy, input bit fl);
        next_y = 10'(ny); sprite_x = 10'(sx); sprite_y = 10'(sy); flip = fl;
        line_start = 1'b1;
        next_cycle();
        line_start = 1'b0;
        sprite_x = 10'd5; sprite_y = 10'd0; flip = ~fl;
    endtask

    task automatic probe(input string name, input int x, input logic [23:0] c, input bit o);
        DrawX = 10'(x);
        next_cycle();
        check({name, "_color"},  32'(pixel_color),  32'(c));
        check({name, "_opaque"}, 32'(pixel_opaque), 32'(o));
    endtask

    task automatic sweep(input int from, input int to);
        for (int x = from; x <= to; x++) begin
            DrawX = 10'(x);
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = {8'h10, 8'(i), 8'(255 - i)};
        rom[44] = TRANSP;

        idle(3);
        Reset_n = 1'b1;
        next_cycle();
        check("rst_busy",   32'(busy),                 32'd0);
        check("rst_addr",   32'(rom_bus.read_address), 32'd0);
        check("rst_color",  32'(pixel_color),          32'd0);
        check("rst_opaque", 32'(pixel_opaque),         32'd0);

        // Hit: row 2 -> addresses 42..62 over 21 cycles
        pulse_line(102, 0, 100, 0);
        check("hit_addr0", 32'(rom_bus.read_address), 32'd42);
        check("hit_busy0", 32'(busy),                 32'd1);
        idle(20);
        check("hit_addr20", 32'(rom_bus.read_address), 32'd62);
        check("hit_busy20", 32'(busy),                 32'd1);
        idle(1);
        check("hit_done_busy", 32'(busy),                 32'd0);
        check("hit_done_addr", 32'(rom_bus.read_address), 32'd62);

        // Display row 2 at sprite_x=300 while row 3 fetches
        pulse_line(103, 300, 100, 0);
        probe("x300", 300, 24'h102AD5, 1'b1);
        probe("x302", 302, 24'h800080, 1'b0);
        probe("x299", 299, 24'h000000, 1'b0);
        probe("x321", 321, 24'h000000, 1'b0);
        probe("x320", 320, 24'h103EC1, 1'b1);
        sweep(295, 325);

        // Miss below sprite: row 3 shown, no fetch
        pulse_line(99, 300, 100, 0);
        check("miss99_busy", 32'(busy), 32'd0);
        probe("row3_x300", 300, 24'h103FC0, 1'b1);
        sweep(295, 325);

        // Miss past bottom: previous miss leaves line empty
        pulse_line(121, 300, 100, 0);
        check("miss121_busy", 32'(busy), 32'd0);
        probe("empty_x305", 305, 24'h000000, 1'b0);
        sweep(295, 325);

        // Abort 10 cycles into a fetch
        pulse_line(110, 300, 100, 0);
        idle(9);
        pulse_line(105, 300, 100, 0);
        check("abort_addr", 32'(rom_bus.read_address), 32'd105);
        check("abort_busy", 32'(busy),                 32'd1);
        idle(1);
        check("abort_addr1", 32'(rom_bus.read_address), 32'd106);
        pulse_line(0, 300, 100, 0);
        probe("aborted_x305", 305, 24'h000000, 1'b0);
        sweep(295, 325);

        // Flip on row 2
        pulse_line(102, 0, 100, 0);
        idle(22);
        pulse_line(0, 300, 100, 1);
        probe("flip_x300", 300, FLIP_BUILD ? 24'h103EC1 : 24'h102AD5, 1'b1);
        probe("flip_x320", 320, FLIP_BUILD ? 24'h102AD5 : 24'h103EC1, 1'b1);
        sweep(295, 325);

        // Asynchronous reset mid-fetch
        pulse_line(104, 300, 100, 0);
        idle(4);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #3;
        Reset_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy),                 32'd0);
        check("arst_addr",   32'(rom_bus.read_address), 32'd0);
        check("arst_opaque", 32'(pixel_opaque),         32'd0);
        idle(2);
        Reset_n = 1'b1;
        next_cycle();
        check("post_rst_busy", 32'(busy), 32'd0);
        pulse_line(0, 300, 100, 0);
        probe("post_rst_x305", 305, 24'h000000, 1'b0);
        sweep(295, 325);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
